// File: rtl/card_dealer.sv
// card_dealer: deals BlackJack ranks 1..13 from a 52-card deck using a seeded 16-bit LFSR.
// Optional `CARD_DEALER_REMAINING_EN adds the o_Remaining (cards left) output.
module card_dealer #(
    parameter int WIDTH     = 12,
    parameter int MAX_TRIES = 8
) (
    input  logic             clk_50M,
    input  logic             i_Rst_n,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_LoadSeed,
    input  logic             i_NewDeck,
    input  logic             i_Draw,
    output logic [3:0]       o_Card,
    output logic [3:0]       o_Value,
    output logic             o_Valid,
    output logic             o_Busy,
`ifdef CARD_DEALER_REMAINING_EN
    output logic [5:0]       o_Remaining,
`endif
    output logic             o_DeckEmpty
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
    localparam logic [5:0]  DECK_SIZE = 6'd52;
    localparam logic [3:0]  LAST_TRY  = 4'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, RAND, SCAN, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] lfsr, seed_ext;
    logic [2:0]  rank_cnt [13];
    logic [5:0]  dealt;
    logic [3:0]  try_cnt, try_next;
    logic [3:0]  idx, idx_next;
    logic [3:0]  cand;
    logic        accept;

    assign seed_ext = 16'(i_Seed);

    // NOTE: sequential state always uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n)
            lfsr <= LFSR_INIT;
        else if (i_LoadSeed)
            lfsr <= (seed_ext == 16'h0000) ? LFSR_INIT : seed_ext;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    // A candidate is accepted when it names a real rank that still has cards left.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cand   = (state == SCAN) ? idx : lfsr[3:0];
        accept = 1'b0;
        for (int i = 0; i < 13; i++)
            if (cand == 4'(i + 1) && rank_cnt[i] < 3'd4)
                accept = 1'b1;
    end

    always_comb begin
        state_next = state;
        try_next   = try_cnt;
        idx_next   = idx;
        case (state)
            IDLE: if (i_Draw && !o_DeckEmpty) begin
                state_next = RAND;
                try_next   = 4'd0;
            end
            RAND: if (accept) begin
                state_next = DONE;
            end else if (try_cnt == LAST_TRY) begin
                state_next = SCAN;
                idx_next   = 4'd1;
            end else begin
                try_next = try_cnt + 4'd1;
            end
            SCAN: if (accept) begin
                state_next = DONE;
            end else if (idx == 4'd13) begin
                state_next = IDLE;
            end else begin
                idx_next = idx + 4'd1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_NewDeck)
            state_next = IDLE;
    end

    always_ff @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            try_cnt <= 4'd0;
            idx     <= 4'd0;
        end else begin
            state   <= state_next;
            try_cnt <= try_next;
            idx     <= idx_next;
        end
    end

    // The dealt rank is captured on entry to DONE and then held until the next deal.
    always_ff @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Card  <= 4'd0;
            o_Value <= 4'd0;
        end else if (state_next == DONE) begin
            o_Card  <= cand;
            o_Value <= (cand >= 4'd10) ? 4'd10 : cand;
        end
    end

    assign o_Valid = (state == DONE);
    assign o_Busy  = (state != IDLE);

    // NOTE: rank_cnt is a tiny register array, not a RAM, so it takes the async reset like any flop.
    always_ff @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < 13; i++)
                rank_cnt[i] <= 3'd0;
            dealt       <= 6'd0;
            o_DeckEmpty <= 1'b0;
        end else if (i_NewDeck) begin
            for (int i = 0; i < 13; i++)
                rank_cnt[i] <= 3'd0;
            dealt       <= 6'd0;
            o_DeckEmpty <= 1'b0;
        end else if (state == DONE) begin
            for (int i = 0; i < 13; i++)
                if (o_Card == 4'(i + 1))
                    rank_cnt[i] <= rank_cnt[i] + 3'd1;
            dealt       <= dealt + 6'd1;
            o_DeckEmpty <= (dealt + 6'd1 == DECK_SIZE);
        end
    end

`ifdef CARD_DEALER_REMAINING_EN
    always_ff @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n)
            o_Remaining <= DECK_SIZE;
        else if (i_NewDeck)
            o_Remaining <= DECK_SIZE;
        else if (state == DONE)
            o_Remaining <= DECK_SIZE - dealt - 6'd1;
    end
`endif

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: drives two card_dealer instances (MAX_TRIES=8 and MAX_TRIES=1) in lockstep
// and checks every deal against a deck/LFSR reference model.
module tb_card_dealer;

    localparam int WIDTH    = 12;
    localparam int TRIES0   = 8;
    localparam int TRIES1   = 1;
    localparam int MAX_WAIT = 30;

    logic             clk_50M    = 1'b0;
    logic             i_Rst_n    = 1'b0;
    logic [WIDTH-1:0] i_Seed     = '0;
    logic             i_LoadSeed = 1'b0;
    logic             i_NewDeck  = 1'b0;
    logic             i_Draw     = 1'b0;

    logic [1:0][3:0] card, value;
    logic [1:0]      valid, busy, empty;
`ifdef CARD_DEALER_REMAINING_EN
    logic [1:0][5:0] remaining;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr;
    int          m_cnt [2][1:13];
    int          obs   [2][1:13];
    int          m_dealt;
    logic [3:0]  last_card [2];
    logic [3:0]  seq_a [10];
    logic [3:0]  seq_c [10];

    always #10 clk_50M = ~clk_50M;

    card_dealer #(.WIDTH(WIDTH), .MAX_TRIES(TRIES0)) u_dut0 (
        .clk_50M(clk_50M), .i_Rst_n(i_Rst_n), .i_Seed(i_Seed), .i_LoadSeed(i_LoadSeed),
        .i_NewDeck(i_NewDeck), .i_Draw(i_Draw), .o_Card(card[0]), .o_Value(value[0]),
        .o_Valid(valid[0]), .o_Busy(busy[0]),
`ifdef CARD_DEALER_REMAINING_EN
        .o_Remaining(remaining[0]),
`endif
        .o_DeckEmpty(empty[0])
    );

    card_dealer #(.WIDTH(WIDTH), .MAX_TRIES(TRIES1)) u_dut1 (
        .clk_50M(clk_50M), .i_Rst_n(i_Rst_n), .i_Seed(i_Seed), .i_LoadSeed(i_LoadSeed),
        .i_NewDeck(i_NewDeck), .i_Draw(i_Draw), .o_Card(card[1]), .o_Value(value[1]),
        .o_Valid(valid[1]), .o_Busy(busy[1]),
`ifdef CARD_DEALER_REMAINING_EN
        .o_Remaining(remaining[1]),
`endif
        .o_DeckEmpty(empty[1])
    );

    // Polynomial x^16+x^14+x^13+x^11+1: shift right, fold the dropped bit back into taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int tries(input int d);
        return (d == 0) ? TRIES0 : TRIES1;
    endfunction

    function automatic logic [3:0] value_of(input logic [3:0] rank);
        if (rank >= 4'd11) return 4'd10;
        return rank;
    endfunction

    always @(posedge clk_50M or negedge i_Rst_n) begin
        if (!i_Rst_n)        m_lfsr <= 16'hACE1;
        else if (i_LoadSeed) m_lfsr <= (i_Seed == '0) ? 16'hACE1 : 16'(i_Seed);
        else                 m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int r = 1; r <= 13; r++) begin
                m_cnt[d][r] = 0;
                obs[d][r]   = 0;
            end
        m_dealt = 0;
    endtask

    // Which rank the deck should yield, and how many cycles after the request, from LFSR state 'start'.
    task automatic predict(input int d, input logic [15:0] start, output logic [3:0] pcard, output int plat);
        logic [15:0] s;
        int          r;
        s     = start;
        pcard = 4'd0;
        plat  = -1;
        for (int t = 0; t < tries(d); t++) begin
            r = int'(s[3:0]);
            if (r >= 1 && r <= 13) begin
                if (m_cnt[d][r] < 4) begin
                    pcard = 4'(r);
                    plat  = t + 2;
                    return;
                end
            end
            s = lfsr_step(s);
        end
        for (int k = 1; k <= 13; k++)
            if (m_cnt[d][k] < 4) begin
                pcard = 4'(k);
                plat  = tries(d) + k + 1;
                return;
            end
    endtask

    task automatic do_reset();
        i_Rst_n = 1'b0; i_Draw = 1'b0; i_NewDeck = 1'b0; i_LoadSeed = 1'b0;
        repeat (3) @(negedge clk_50M);
        clear_model();
        i_Rst_n = 1'b1;
    endtask

    task automatic pulse_newdeck();
        i_NewDeck = 1'b1;
        @(negedge clk_50M);
        i_NewDeck = 1'b0;
        clear_model();
    endtask

    task automatic load_seed(input logic [WIDTH-1:0] s);
        i_Seed = s; i_LoadSeed = 1'b1;
        @(negedge clk_50M);
        i_LoadSeed = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    // One draw request (optionally repeated while busy); expects either one deal per DUT or none.
    task automatic do_draw(input bit second_draw, input bit expect_deal);
        logic [3:0]  pcard [2];
        int          plat  [2];
        bit          seen  [2];
        logic [15:0] start;
        start = lfsr_step(m_lfsr);
        for (int d = 0; d < 2; d++) begin
            seen[d] = 1'b0; pcard[d] = 4'd0; plat[d] = 0;
            if (expect_deal) predict(d, start, pcard[d], plat[d]);
        end
        i_Draw = 1'b1;
        for (int n = 1; n <= MAX_WAIT; n++) begin
            @(negedge clk_50M);
            i_Draw = second_draw && (n == 1);
            for (int d = 0; d < 2; d++) begin
                if (valid[d] && expect_deal && !seen[d]) begin
                    seen[d] = 1'b1;
                    last_card[d] = card[d];
                    if (card[d] >= 4'd1 && card[d] <= 4'd13) obs[d][card[d]]++;
                    n_cmp++;
                    if (card[d] !== pcard[d]) begin
                        n_err++;
                        $display("FAIL card dut%0d: got %0d, expected %0d", d, card[d], pcard[d]);
                    end
                    n_cmp++;
                    if (value[d] !== value_of(pcard[d])) begin
                        n_err++;
                        $display("FAIL value dut%0d: got %0d, expected %0d", d, value[d], value_of(pcard[d]));
                    end
                    n_cmp++;
                    if (n != plat[d]) begin
                        n_err++;
                        $display("FAIL latency dut%0d: got %0d cycles, expected %0d", d, n, plat[d]);
                    end
                    n_cmp++;
                    if (n > tries(d) + 14) begin
                        n_err++;
                        $display("FAIL latency_bound dut%0d: got %0d cycles, limit %0d", d, n, tries(d) + 14);
                    end
                end else begin
                    n_cmp++;
                    if (valid[d] !== 1'b0) begin
                        n_err++;
                        $display("FAIL stray_valid dut%0d: o_Valid=%b at cycle %0d, expected 0", d, valid[d], n);
                    end
                end
                if (!expect_deal) begin
                    n_cmp++;
                    if (busy[d] !== 1'b0) begin
                        n_err++;
                        $display("FAIL ignored_busy dut%0d: o_Busy=%b, expected 0", d, busy[d]);
                    end
                end
            end
            if (expect_deal && seen[0] && seen[1]) break;
        end
        i_Draw = 1'b0;
        @(negedge clk_50M);
        if (expect_deal) begin
            for (int d = 0; d < 2; d++)
                if (pcard[d] >= 4'd1 && pcard[d] <= 4'd13) m_cnt[d][pcard[d]]++;
            m_dealt++;
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (seen[d] !== expect_deal) begin
                n_err++;
                $display("FAIL deal_seen dut%0d: got %0d, expected %0d", d, seen[d], expect_deal);
            end
            n_cmp++;
            if (busy[d] !== 1'b0 || valid[d] !== 1'b0) begin
                n_err++;
                $display("FAIL post_idle dut%0d: busy=%b valid=%b, expected 0/0", d, busy[d], valid[d]);
            end
            n_cmp++;
            if (empty[d] !== (m_dealt == 52)) begin
                n_err++;
                $display("FAIL deck_empty dut%0d: got %b, expected %b", d, empty[d], m_dealt == 52);
            end
`ifdef CARD_DEALER_REMAINING_EN
            n_cmp++;
            if (remaining[d] !== 6'(52 - m_dealt)) begin
                n_err++;
                $display("FAIL remaining dut%0d: got %0d, expected %0d", d, remaining[d], 52 - m_dealt);
            end
`endif
        end
    endtask

    task automatic check_tally();
        for (int d = 0; d < 2; d++)
            for (int r = 1; r <= 13; r++) begin
                n_cmp++;
                if (obs[d][r] !== 4) begin
                    n_err++;
                    $display("FAIL tally dut%0d rank %0d: dealt %0d times, expected 4", d, r, obs[d][r]);
                end
            end
    endtask

    task automatic deal_deck(input int n_cards);
        for (int k = 0; k < n_cards; k++) begin
            do_draw(1'b0, 1'b1);
            idle($urandom_range(0, 3));
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({card[d], value[d], valid[d], busy[d], empty[d]} !== 11'd0) begin
                n_err++;
                $display("FAIL reset dut%0d: card=%0d value=%0d valid=%b busy=%b empty=%b, expected all 0",
                         d, card[d], value[d], valid[d], busy[d], empty[d]);
            end
`ifdef CARD_DEALER_REMAINING_EN
            n_cmp++;
            if (remaining[d] !== 6'd52) begin
                n_err++;
                $display("FAIL reset_remaining dut%0d: got %0d, expected 52", d, remaining[d]);
            end
`endif
        end
    endtask

    task automatic test_full_deck();
        pulse_newdeck();
        deal_deck(52);
        check_tally();
        do_draw(1'b0, 1'b0);
    endtask

    task automatic test_seed_determinism();
        do_reset();
        load_seed('0);
        for (int k = 0; k < 10; k++) begin
            do_draw(1'b0, 1'b1);
            seq_a[k] = last_card[0];
        end
        do_reset();
        load_seed(12'h0E1);
        for (int k = 0; k < 10; k++) do_draw(1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            do_draw(1'b0, 1'b1);
            seq_c[k] = last_card[0];
        end
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (seq_c[k] !== seq_a[k]) begin
                n_err++;
                $display("FAIL determinism card %0d: unseeded %0d, seed-0 run %0d", k, seq_c[k], seq_a[k]);
            end
        end
    endtask

    task automatic test_random_seeds();
        for (int it = 0; it < 4; it++) begin
            pulse_newdeck();
            load_seed(WIDTH'($urandom));
            idle($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) do_draw(1'b0, 1'b1);
        end
    endtask

    task automatic test_latency();
        pulse_newdeck();
        load_seed(WIDTH'($urandom));
        deal_deck(48);
        deal_deck(4);
        check_tally();
    endtask

    task automatic test_abort();
        pulse_newdeck();
        deal_deck(5);
        i_Draw = 1'b1;
        @(negedge clk_50M);
        i_Draw = 1'b0; i_NewDeck = 1'b1;
        @(negedge clk_50M);
        i_NewDeck = 1'b0;
        clear_model();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (busy[d] !== 1'b0 || empty[d] !== 1'b0) begin
                n_err++;
                $display("FAIL abort dut%0d: busy=%b empty=%b, expected 0/0", d, busy[d], empty[d]);
            end
            n_cmp++;
            if (card[d] !== last_card[d]) begin
                n_err++;
                $display("FAIL abort_hold dut%0d: card %0d, expected %0d", d, card[d], last_card[d]);
            end
        end
        i_Draw = 1'b1; i_NewDeck = 1'b1;
        @(negedge clk_50M);
        i_Draw = 1'b0; i_NewDeck = 1'b0;
        for (int n = 0; n < 20; n++) begin
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_quiet dut%0d: valid=%b busy=%b, expected 0/0", d, valid[d], busy[d]);
                end
            end
            @(negedge clk_50M);
        end
        deal_deck(52);
        check_tally();
    endtask

    task automatic test_back_to_back();
        pulse_newdeck();
        for (int k = 0; k < 3; k++) do_draw(1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_deck();
        test_seed_determinism();
        test_random_seeds();
        test_latency();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Random card source for the BlackJack datapath; sits directly downstream of the seed counter.
- Takes the counter's WIDTH-bit count as an entropy seed and deals ranks 1..13 on request from a single 52-card deck model (max 4 per rank).
- Feeds the hand/score logic through a one-cycle valid pulse.
- Every draw terminates in bounded time, even with a nearly exhausted deck.

Parameters:
- WIDTH, 12, width of i_Seed; matches the seed counter's count width.
- MAX_TRIES, 8, random attempts per draw before falling back to a linear scan; legal range 1..15.

Ports:
- clk_50M  in  1  50 MHz system clock; single clock domain.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Seed  in  WIDTH  seed value, normally the seed counter's count output.
- i_LoadSeed  in  1  1-cycle pulse: load i_Seed into the LFSR.
- i_NewDeck  in  1  1-cycle pulse: restore the full 52-card deck.
- i_Draw  in  1  1-cycle pulse: request one card.
- o_Card  out  4  last dealt rank, 1..13 (1=A, 11=J, 12=Q, 13=K).
- o_Value  out  4  BlackJack value of o_Card: A=1, 2..10=rank, J/Q/K=10.
- o_Valid  out  1  1-cycle pulse; o_Card and o_Value are new this cycle.
- o_Busy  out  1  high while a draw is in progress.
- o_DeckEmpty  out  1  high when all 52 cards have been dealt.

Behaviour:
- Reset values (i_Rst_n=0, asynchronous):
  - LFSR=16'hACE1; all 13 rank counters=0; dealt counter=0; state=IDLE.
  - o_Card=0, o_Value=0, o_Valid=0, o_Busy=0, o_DeckEmpty=0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk_50M cycle in every state.
  - i_LoadSeed loads {zero-pad, i_Seed} in place of advancing that cycle.
  - A loaded value of 0 is replaced by 16'hACE1.
- Rank counters: 13 x 3-bit, each 0..4. Dealt counter: 6-bit, 0..52.
- o_DeckEmpty = (dealt == 52), registered.
- Candidate acceptance rule: candidate is in 1..13 AND its rank counter < 4.
- FSM:
  - IDLE: i_Draw with o_DeckEmpty=0 -> RAND, try counter=0. i_Draw with o_DeckEmpty=1 is ignored; no o_Valid.
  - RAND: candidate = LFSR[3:0] each cycle. If accepted -> DONE. Else try counter+1; when the failed try is number MAX_TRIES -> SCAN with idx=1.
  - SCAN: candidate = idx. If accepted -> DONE; else idx+1. Always terminates by idx=13 because the deck is non-empty.
  - DONE: o_Card and o_Value registered; o_Valid=1 for exactly this cycle; rank counter+1; dealt+1; -> IDLE.
- Latency: o_Valid is high 2 cycles after the i_Draw cycle at minimum, and at most MAX_TRIES+14 cycles after.
- o_Busy = state is RAND, SCAN or DONE.
- i_Draw while o_Busy=1 is ignored; it is not queued.
- i_NewDeck, any state:
  - Clears rank counters and dealt counter; goes to IDLE.
  - Aborts an in-progress draw: no o_Valid for it, no counter update.
  - o_Card and o_Value keep their last value.
  - Has priority over an i_Draw in the same cycle.
- i_LoadSeed is legal in any state; an in-progress draw continues using the new LFSR stream.
- o_Card and o_Value hold their value between draws.

Optional Feature:
- Macro: CARD_DEALER_REMAINING_EN.
- Defined: adds output port o_Remaining (6 bits) = 52 - dealt, registered.
  - Resets to 52.
  - Decrements in the cycle after each DONE.
  - Returns to 52 on i_NewDeck.
- Undefined: port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold i_Rst_n=0, then release -> o_Card=0, o_Value=0, o_Valid=0, o_Busy=0, o_DeckEmpty=0; with the macro defined, o_Remaining=52.
- Full deck: issue 52 draws, each after o_Busy falls -> 52 o_Valid pulses; every rank 1..13 appears exactly 4 times; o_Value matches the rank mapping (e.g. card 12 -> value 10); o_DeckEmpty=1 after the 52nd; a 53rd i_Draw gives no o_Valid and o_Busy stays 0.
- Seed determinism: load seed 0, draw 10 cards; reset, load 12'h0E1 (LFSR 16'h00E1), draw 10 cards; reset, draw 10 cards with no load (LFSR 16'hACE1) -> the first and third sequences are identical.
- Latency bound: MAX_TRIES=1, 48 cards dealt -> each of the remaining 4 draws asserts o_Valid within 15 cycles of i_Draw, and all are the still-available ranks.
- Abort: i_Draw, then i_NewDeck on the next cycle -> no o_Valid; o_Busy=0 in the following cycle; o_DeckEmpty=0; a subsequent 52-draw run completes with exactly 4 of each rank.
- Ignored request: second i_Draw while o_Busy=1 -> exactly one o_Valid; dealt count (o_Remaining) changes by 1.
